// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared memory geometry, burst master state and command types
package mem_pkg;

  localparam int WIDTH      = 32;
  localparam int DEPTH      = 16;
  localparam int ADDR_WIDTH = $clog2(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WDATA = 3'd1,
    ST_ISSUE = 3'd2,
    ST_GAP   = 3'd3,
    ST_DONE  = 3'd4
  } mem_mst_state_t;

  // Running burst command: direction, current beat address, beats remaining
  typedef struct packed {
    logic                  wr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH:0]   len;
  } mem_cmd_t;

endpackage

// File: rtl/mem_burst_master_if.sv
// rtl/mem_burst_master_if.sv - valid/ready single-port memory bus between burst master and memory
interface mem_burst_master_if
  import mem_pkg::*;
();

  logic [ADDR_WIDTH-1:0] addr_o;
  logic [WIDTH-1:0]      wdata_o;
  logic                  wr_rd_o;
  logic                  valid_o;
  logic                  ready_i;
  logic [WIDTH-1:0]      rdata_i;

  modport master (
    output addr_o, wdata_o, wr_rd_o, valid_o,
    input  ready_i, rdata_i
  );

  modport slave (
    input  addr_o, wdata_o, wr_rd_o, valid_o,
    output ready_i, rdata_i
  );

endinterface

// File: rtl/mem_burst_master.sv
// rtl/mem_burst_master.sv - burst initiator for the single-port memory; MEM_BURST_MASTER_TIMEOUT_EN adds ISSUE timeout and err_o
module mem_burst_master
  import mem_pkg::*;
`ifdef MEM_BURST_MASTER_TIMEOUT_EN
#(
  parameter int TIMEOUT = 15
)
`endif
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  cmd_wr_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH:0]   len_i,
  output logic                  busy_o,
  output logic                  done_o,
  input  logic [WIDTH-1:0]      wd_data_i,
  input  logic                  wd_valid_i,
  output logic                  wd_ready_o,
  output logic [WIDTH-1:0]      rd_data_o,
  output logic                  rd_valid_o,
  input  logic                  rd_ready_i,
  mem_burst_master_if.master    mem
`ifdef MEM_BURST_MASTER_TIMEOUT_EN
  ,
  output logic                  err_o
`endif
);

  mem_mst_state_t        r_state;
  mem_mst_state_t        w_next;
  mem_cmd_t              r_cmd;
  logic [WIDTH-1:0]      r_wdata;
  logic [WIDTH-1:0]      r_rd_data;
  logic                  r_rd_valid;
  logic [ADDR_WIDTH:0]   w_len;
  logic [ADDR_WIDTH-1:0] w_addr_nxt;
  logic                  w_timeout;

  assign w_len      = (len_i > (ADDR_WIDTH+1)'(DEPTH)) ? (ADDR_WIDTH+1)'(DEPTH) : len_i;
  assign w_addr_nxt = (r_cmd.addr == ADDR_WIDTH'(DEPTH-1)) ? '0 : r_cmd.addr + 1'b1;

`ifdef MEM_BURST_MASTER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT+1);
  logic [TO_W-1:0] r_to_cnt;
  logic            r_err;

  assign w_timeout = (r_state == ST_ISSUE) && !mem.ready_i && (r_to_cnt == TO_W'(TIMEOUT-1));
  assign err_o     = r_err;

  // Count ISSUE cycles without an ack; sticky error until the next accepted command
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_to_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      if (r_state == ST_ISSUE && !mem.ready_i && !w_timeout)
        r_to_cnt <= r_to_cnt + 1'b1;
      else
        r_to_cnt <= '0;
      if (w_timeout)
        r_err <= 1'b1;
      else if (r_state == ST_IDLE && start_i)
        r_err <= 1'b0;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state: GAP waits for the slave's lagging ready to fall before the next beat
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (start_i) w_next = (w_len == '0) ? ST_DONE : (cmd_wr_i ? ST_WDATA : ST_ISSUE);
      ST_WDATA: if (wd_valid_i) w_next = ST_ISSUE;
      ST_ISSUE: begin
        if (mem.ready_i)    w_next = ST_GAP;
        else if (w_timeout) w_next = ST_DONE;
      end
      ST_GAP: begin
        if (!mem.ready_i) begin
          if (r_cmd.len == '0)                w_next = ST_DONE;
          else if (r_cmd.wr)                  w_next = ST_WDATA;
          else if (!r_rd_valid || rd_ready_i) w_next = ST_ISSUE;
        end
      end
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Command latch, beat advance on ack, write data capture and read data holding register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cmd      <= '0;
      r_wdata    <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (start_i) begin
          r_cmd.wr   <= cmd_wr_i;
          r_cmd.addr <= base_addr_i;
          r_cmd.len  <= w_len;
        end
        ST_WDATA: if (wd_valid_i) r_wdata <= wd_data_i;
        ST_ISSUE: if (mem.ready_i) begin
          r_cmd.len  <= r_cmd.len - 1'b1;
          r_cmd.addr <= w_addr_nxt;
        end
        default: ;
      endcase
      if (r_state == ST_ISSUE && mem.ready_i && !r_cmd.wr) begin
        r_rd_valid <= 1'b1;
        r_rd_data  <= mem.rdata_i;
      end else if (r_rd_valid && rd_ready_i) begin
        r_rd_valid <= 1'b0;
      end
    end
  end

  assign busy_o      = (r_state != ST_IDLE);
  assign done_o      = (r_state == ST_DONE);
  assign wd_ready_o  = (r_state == ST_WDATA);
  assign rd_data_o   = r_rd_data;
  assign rd_valid_o  = r_rd_valid;
  assign mem.valid_o = (r_state == ST_ISSUE);
  assign mem.addr_o  = r_cmd.addr;
  assign mem.wdata_o = r_wdata;
  assign mem.wr_rd_o = r_cmd.wr;

endmodule
